// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: DEPTH-entry {pc, instr} prefetch buffer between instruction memory and IF.
// Sequential PC generation with a single outstanding request, flush/redirect, and
// misaligned-target detection. Optional build macro IFQ_BYPASS_EN forwards a response
// straight to IF when the queue is empty.
module instr_fetch_queue #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [ADDR_W-1:0]      flush_pc_i,
  output logic                   instr_rd_en_o,
  output logic [ADDR_W-1:0]      pc_o,
  input  logic                   instr_vld_i,
  input  logic [INSTR_W-1:0]     instr_i,
  output logic                   if_vld_o,
  output logic [INSTR_W-1:0]     if_instr_o,
  output logic [ADDR_W-1:0]      if_pc_o,
  input  logic                   if_rdy_i,
  output logic                   fetch_except_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned    PtrW    = $clog2(DEPTH);
  localparam int unsigned    CntW    = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic               except_q;
  logic [CntW-1:0]    count_q;
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];

  logic resp_ok, bypass, head_vld, push, pop;

  // Qualify the memory response and resolve push/pop; flush overrides both.
  always_comb begin
    resp_ok  = (state_q == StWait) && instr_vld_i && !flush_i;
    head_vld = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass   = resp_ok && !head_vld;
`else
    bypass   = 1'b0;
`endif
    pop      = head_vld && if_rdy_i && !flush_i;
    // A bypassed response that IF takes immediately is never written.
    push     = resp_ok && !(bypass && if_rdy_i);
  end

  // Next fetch state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Slot is free whenever count < DEPTH: IDLE never has a response in flight.
        if (!flush_i && !except_q && (count_q < FullCnt)) state_d = StWait;
      end
      StWait: begin
        if (flush_i)          state_d = instr_vld_i ? StIdle : StDrop;
        else if (instr_vld_i) state_d = StIdle;
      end
      StDrop: begin
        // The abandoned response ends DROP even if a new flush lands on the same cycle;
        // otherwise no further response would ever come to release it.
        if (instr_vld_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: request held from WAIT state, head read combinationally from storage.
  always_comb begin
    instr_rd_en_o  = (state_q == StWait);
    pc_o           = pc_q;
    fetch_except_o = except_q;
    count_o        = count_q;
    if_vld_o       = head_vld || bypass;
    if_instr_o     = '0;
    if_pc_o        = '0;
    if (bypass) begin
      if_instr_o = instr_i;
      if_pc_o    = pc_q;
    end else if (head_vld) begin
      if_instr_o = mem_instr_q[rd_ptr_q];
      if_pc_o    = mem_pc_q[rd_ptr_q];
    end
  end

  // Control state: FSM, fetch PC, exception flag, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      except_q <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        pc_q     <= {flush_pc_i[ADDR_W-1:2], 2'b00};
        except_q <= (flush_pc_i[1:0] != 2'b00);
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (resp_ok) pc_q <= pc_q + ADDR_W'(4);
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry storage; written only on a qualified push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= instr_i;
    end
  end

endmodule
